// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// stream-format constants.
package imem_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_INS_LO,
    S_INS_HI,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Bits [7:1] of an instruction HI byte are reserved and must be zero.
  localparam logic [7:0] HI_RSVD_MASK = 8'hFE;
  localparam int DEFAULT_IMEM_DEPTH = 2048;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: reassembles 9-bit words and writes them into
// instruction memory. It keeps the core held until a checksum-verified image is present.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = DEFAULT_IMEM_DEPTH,
  parameter int ADDR_W     = 11,
  parameter int INST_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [INST_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              err
);

  localparam int CNT_W = $clog2(IMEM_DEPTH + 1);

  state_t             state, next_state;
  logic [7:0]         lo_byte;
  logic [7:0]         xor_acc;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   word_total;

  logic               xfer;
  logic               go;
  logic [15:0]        cnt16;
  logic               cnt_over;
  logic               cnt_zero;
  logic               last_word;

  assign xfer      = s_valid && s_ready;
  assign go        = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign cnt16     = {s_data, lo_byte};
  assign cnt_over  = {16'd0, cnt16} > 32'(IMEM_DEPTH);
  assign cnt_zero  = (cnt16 == 16'd0);
  assign last_word = (word_cnt + CNT_W'(1)) == word_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_CNT_LO;
      S_CNT_LO: if (xfer) next_state = S_CNT_HI;
      S_CNT_HI: begin
        if (xfer) begin
          if (cnt_over)      next_state = S_ERR;
          else if (cnt_zero) next_state = S_CHK;
          else               next_state = S_INS_LO;
        end
      end
      S_INS_LO: if (xfer) next_state = S_INS_HI;
      S_INS_HI: begin
        if (xfer) next_state = |(s_data & HI_RSVD_MASK) ? S_ERR : S_WRITE;
      end
      S_WRITE:  next_state = last_word ? S_CHK : S_INS_LO;
      S_CHK: begin
        if (xfer) next_state = (s_data == xor_acc) ? S_DONE : S_ERR;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // All status outputs decode the registered state only, so s_ready has
  // no combinational dependence on s_valid.
  always_comb begin
    s_ready   = 1'b0;
    im_we     = 1'b0;
    busy      = 1'b1;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_CNT_LO, S_CNT_HI, S_INS_LO, S_INS_HI, S_CHK: s_ready = 1'b1;
      S_WRITE: im_we = 1'b1;
      S_DONE: begin
        busy      = 1'b0;
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_byte    <= '0;
      xor_acc    <= '0;
      word_cnt   <= '0;
      word_total <= '0;
      im_addr    <= '0;
      im_wdata   <= '0;
    end else if (go) begin
      xor_acc  <= '0;
      word_cnt <= '0;
      im_addr  <= '0;
    end else begin
      // The checksum byte itself is not folded into the running XOR.
      if (xfer && state != S_CHK) xor_acc <= xor_acc ^ s_data;
      if (xfer && (state == S_CNT_LO || state == S_INS_LO)) lo_byte <= s_data;
      if (xfer && state == S_CNT_HI) word_total <= cnt16[CNT_W-1:0];
      if (xfer && state == S_INS_HI) im_wdata <= INST_W'({s_data[0], lo_byte});
      if (state == S_WRITE) begin
        word_cnt <= word_cnt + CNT_W'(1);
        im_addr  <= im_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader; expected writes and outcome
// come from a stream-level parser of the image format.
module tb_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [19:0] wq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready, im_we, cpu_hold, busy, load_done, err;
  logic [10:0] im_addr;
  logic [8:0]  im_wdata;

  int  n_checks = 0;
  int  n_fail = 0;
  wq_t seen;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (im_we) seen.push_back({im_addr, im_wdata});

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bq_t good_img;
  initial good_img = '{8'h03, 8'h00, 8'hA5, 8'h01, 8'h03, 8'h00, 8'h00, 8'h01, 8'hA5};

  // Reference: parse the image by its format rules.
  task automatic model(input bq_t b, output wq_t exp, output bit e);
    int n;
    logic [7:0] x, lo, hi;
    exp = {};
    e = 1'b0;
    n = int'({b[1], b[0]});
    if (n > 2048) begin e = 1'b1; return; end
    x = b[0] ^ b[1];
    for (int i = 0; i < n; i++) begin
      lo = b[2 + 2 * i];
      hi = b[3 + 2 * i];
      x = x ^ lo ^ hi;
      if (hi[7:1] != 7'd0) begin e = 1'b1; return; end
      exp.push_back({11'(i), hi[0], lo});
    end
    e = (b[2 + 2 * n] != x);
  endtask

  task automatic build(input int n, input int mode, output bq_t b);
    logic [7:0] x, lo, hi;
    logic [8:0] w;
    logic [15:0] n16;
    int bad;
    b = {};
    n16 = 16'(n);
    b.push_back(n16[7:0]);
    b.push_back(n16[15:8]);
    bad = (mode == 2 && n > 0) ? int'($urandom_range(n - 1)) : -1;
    for (int i = 0; i < n; i++) begin
      w  = 9'($urandom);
      lo = w[7:0];
      hi = {7'd0, w[8]};
      if (i == bad) hi[$urandom_range(7, 1)] = 1'b1;
      b.push_back(lo);
      b.push_back(hi);
    end
    x = 8'd0;
    foreach (b[i]) x ^= b[i];
    if (mode == 1 || (mode == 2 && n == 0)) x ^= 8'(1 << $urandom_range(7));
    b.push_back(x);
  endtask

  // Pulses start, then offers bytes (with random gaps) until DONE/ERR,
  // stop_at bytes accepted, or the cycle budget runs out.
  task automatic run_stream(input bq_t b, input int gap_pct, input int stop_at, output int cycles);
    int idx;
    bit xf;
    @(negedge clk);
    start = 1'b1;
    s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    cycles = 1;
    while (cycles < 20000) begin
      if (stop_at >= 0 && idx == stop_at) begin s_valid = 1'b0; return; end
      if (load_done || err) break;
      if (idx < b.size() && int'($urandom_range(99)) >= gap_pct) begin
        s_valid = 1'b1;
        s_data = b[idx];
      end else begin
        s_valid = 1'b0;
        s_data = 8'($urandom);
      end
      xf = s_valid && s_ready;
      @(negedge clk);
      cycles++;
      if (xf) idx++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (cycles >= 20000) begin
      n_fail++;
      $display("FAIL stream_timeout: cycles=%0d bytes_taken=%0d required completion", cycles, idx);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, im_we, busy, load_done, err, cpu_hold} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000001", {s_ready, im_we, busy, load_done, err, cpu_hold});
    end
    n_checks++;
    if ({im_addr, im_wdata} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h/%h required 0/0", im_addr, im_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_image();
    int cyc;
    logic [19:0] exp [3];
    exp = '{{11'd0, 9'h1A5}, {11'd1, 9'h003}, {11'd2, 9'h100}};
    seen = {};
    run_stream(good_img, 0, -1, cyc);
    n_checks++;
    if (cyc !== 13) begin n_fail++; $display("FAIL good_latency: got %0d cycles required 13", cyc); end
    n_checks++;
    if (seen.size() !== 3) begin n_fail++; $display("FAIL good_nwrites: got %0d required 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_checks++;
      if (seen[i] !== exp[i]) begin n_fail++; $display("FAIL good_write%0d: got %h required %h", i, seen[i], exp[i]); end
    end
    n_checks++;
    if ({load_done, cpu_hold, err, busy, s_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL good_status: got %b required 10000", {load_done, cpu_hold, err, busy, s_ready});
    end
  endtask

  task automatic test_empty();
    int cyc;
    bq_t b;
    b = '{8'h00, 8'h00, 8'h00};
    seen = {};
    run_stream(b, 0, -1, cyc);
    n_checks++;
    if (seen.size() !== 0) begin n_fail++; $display("FAIL empty_nwrites: got %0d required 0", seen.size()); end
    n_checks++;
    if ({load_done, err, cpu_hold} !== 3'b100) begin n_fail++; $display("FAIL empty_status: got %b required 100", {load_done, err, cpu_hold}); end
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL empty_latency: got %0d required 4", cyc); end
  endtask

  task automatic test_bad_checksum();
    int cyc;
    bq_t b;
    b = good_img;
    b[8] = 8'hA4;
    seen = {};
    run_stream(b, 0, -1, cyc);
    n_checks++;
    if ({err, cpu_hold, load_done} !== 3'b110) begin n_fail++; $display("FAIL badchk_status: got %b required 110", {err, cpu_hold, load_done}); end
    n_checks++;
    if (seen.size() !== 3) begin n_fail++; $display("FAIL badchk_nwrites: got %0d required 3", seen.size()); end
    seen = {};
    run_stream(good_img, 0, -1, cyc);
    n_checks++;
    if ({load_done, err, cpu_hold} !== 3'b100) begin n_fail++; $display("FAIL badchk_restart: got %b required 100", {load_done, err, cpu_hold}); end
    n_checks++;
    if (seen.size() !== 3 || seen[2] !== {11'd2, 9'h100}) begin
      n_fail++;
      $display("FAIL badchk_rewrite: got n=%0d required n=3 last=%h", seen.size(), {11'd2, 9'h100});
    end
  endtask

  task automatic test_hi_error();
    int cyc;
    bq_t b;
    b = '{8'h03, 8'h00, 8'hA5, 8'h02, 8'h03, 8'h00, 8'h00, 8'h01, 8'hA6};
    seen = {};
    run_stream(b, 0, -1, cyc);
    n_checks++;
    if ({err, load_done, busy, s_ready} !== 4'b1000) begin n_fail++; $display("FAIL hierr0_status: got %b required 1000", {err, load_done, busy, s_ready}); end
    n_checks++;
    if (seen.size() !== 0) begin n_fail++; $display("FAIL hierr0_nwrites: got %0d required 0", seen.size()); end
    b = '{8'h02, 8'h00, 8'h11, 8'h00, 8'h22, 8'h04, 8'h35};
    seen = {};
    run_stream(b, 0, -1, cyc);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL hierr1_err: got %b required 1", err); end
    n_checks++;
    if (seen.size() !== 1 || seen[0] !== {11'd0, 9'h011}) begin
      n_fail++;
      $display("FAIL hierr1_writes: got n=%0d required n=1 first=%h", seen.size(), {11'd0, 9'h011});
    end
  endtask

  task automatic test_count_overflow();
    int cyc;
    bq_t b;
    b = '{8'h01, 8'h08, 8'h00, 8'h00};
    seen = {};
    run_stream(b, 0, -1, cyc);
    n_checks++;
    if ({err, load_done, cpu_hold} !== 3'b101) begin n_fail++; $display("FAIL overflow_status: got %b required 101", {err, load_done, cpu_hold}); end
    n_checks++;
    if (seen.size() !== 0) begin n_fail++; $display("FAIL overflow_nwrites: got %0d required 0", seen.size()); end
  endtask

  task automatic test_stalls();
    int cyc;
    logic [19:0] exp [3];
    exp = '{{11'd0, 9'h1A5}, {11'd1, 9'h003}, {11'd2, 9'h100}};
    seen = {};
    run_stream(good_img, 45, -1, cyc);
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b required 1", load_done); end
    n_checks++;
    if (seen.size() !== 3) begin n_fail++; $display("FAIL stall_nwrites: got %0d required 3", seen.size()); end
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      n_checks++;
      if (seen[i] !== exp[i]) begin n_fail++; $display("FAIL stall_write%0d: got %h required %h", i, seen[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bq_t b;
    b = '{8'h00, 8'h00, 8'h00};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({cpu_hold, busy, s_ready, load_done} !== 4'b1110) begin
      n_fail++;
      $display("FAIL restart_from_done: got %b required 1110", {cpu_hold, busy, s_ready, load_done});
    end
    seen = {};
    run_stream(b, 0, -1, cyc);
    n_checks++;
    if ({load_done, err} !== 2'b10 || seen.size() !== 0) begin
      n_fail++;
      $display("FAIL restart_empty: got done/err=%b nwrites=%0d required 10 and 0", {load_done, err}, seen.size());
    end
  endtask

  task automatic run_random_case(input int n, input int mode, input int gap);
    int cyc;
    bq_t b;
    wq_t exp;
    bit e;
    build(n, mode, b);
    model(b, exp, e);
    seen = {};
    run_stream(b, gap, -1, cyc);
    n_checks++;
    if ({err, load_done, cpu_hold} !== {e, !e, e}) begin
      n_fail++;
      $display("FAIL rand_status n=%0d mode=%0d: got %b required %b", n, mode, {err, load_done, cpu_hold}, {e, !e, e});
    end
    n_checks++;
    if (seen.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL rand_nwrites n=%0d mode=%0d: got %0d required %0d", n, mode, seen.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      n_checks++;
      if (seen[i] !== exp[i]) begin n_fail++; $display("FAIL rand_write%0d: got %h required %h", i, seen[i], exp[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++)
      run_random_case(int'($urandom_range(8)), int'($urandom_range(2)), int'($urandom_range(50)));
  endtask

  task automatic test_full_depth();
    run_random_case(2048, 0, 0);
    n_checks++;
    if (seen.size() != 0 && seen[seen.size() - 1][19:9] !== 11'd2047) begin
      n_fail++;
      $display("FAIL full_last_addr: got %0d required 2047", seen[seen.size() - 1][19:9]);
    end
  endtask

  task automatic test_abort();
    int cyc;
    seen = {};
    run_stream(good_img, 0, 5, cyc);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({cpu_hold, im_we, busy, s_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_flags: got %b required 1000", {cpu_hold, im_we, busy, s_ready});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (seen.size() !== 1 || seen[0] !== {11'd0, 9'h1A5}) begin
      n_fail++;
      $display("FAIL abort_writes: got n=%0d required n=1 first=%h", seen.size(), {11'd0, 9'h1A5});
    end
    n_checks++;
    if ({cpu_hold, busy, load_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_idle: got %b required 100", {cpu_hold, busy, load_done});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_good_image();
    test_empty();
    test_bad_checksum();
    test_hi_error();
    test_count_overflow();
    test_stalls();
    test_back_to_back();
    test_random();
    test_full_depth();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side program loader for the 9-bit single-cycle core. It accepts a byte stream over a valid/ready handshake and reassembles 9-bit instruction words. It writes those words into instruction memory through its write port and holds the core in reset until a complete, checksum-verified image is in place. It is the writer for the imem read port that the PC drives.

## Interface
Parameters:
- IMEM_DEPTH, 2048: instruction-memory words; matches the 11-bit PC.
- ADDR_W, 11: im_addr width.
- INST_W, 9: instruction width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE, ERR
- s_valid  input  1  host byte valid
- s_data  input  8  host byte
- s_ready  output  1  loader can accept a byte
- im_we  output  1  instruction-memory write strobe, one cycle per word
- im_addr  output  ADDR_W  write address
- im_wdata  output  INST_W  write data
- cpu_hold  output  1  holds core reset/PC at 0 while high
- busy  output  1  load in progress
- load_done  output  1  image loaded and verified
- err  output  1  protocol or checksum failure

## Operation
- Stream format, little-endian:
  - CNT_LO, CNT_HI: 16-bit word count N.
  - For each of N words: LO byte = inst[7:0]; HI byte bit0 = inst[8], bits[7:1] must be 0.
  - One checksum byte = XOR of every preceding byte in the stream.
- States:
  - IDLE: start → CNT_LO.
  - CNT_LO: byte accepted → CNT_HI.
  - CNT_HI: byte accepted; N > IMEM_DEPTH → ERR; N == 0 → CHK; else → INS_LO.
  - INS_LO: byte accepted → INS_HI.
  - INS_HI: byte accepted; HI[7:1] ≠ 0 → ERR; else → WRITE.
  - WRITE: im_we pulse. If this was word N → CHK; else → INS_LO.
  - CHK: byte accepted; byte == running XOR → DONE; else → ERR.
  - DONE: start → CNT_LO.
  - ERR: start → CNT_LO.
- Output behaviour by state:
  - s_ready = 1 only in CNT_LO, CNT_HI, INS_LO, INS_HI, CHK. It is decoded from the registered state, with no combinational path from s_valid.
  - im_we = 1 only in WRITE. im_addr and im_wdata are valid in the same cycle.
  - im_addr resets to 0 on entry to CNT_LO and increments after each WRITE, so the last write is at address N−1. No wrap is possible because N ≤ IMEM_DEPTH.
  - busy = 1 in every state except IDLE, DONE, ERR.
  - cpu_hold = 1 in every state except DONE.
  - load_done = 1 only in DONE.
  - err = 1 only in ERR.
- Running XOR and word counter clear on entry to CNT_LO.
- start is ignored while busy. A start in DONE reasserts cpu_hold on the next cycle.
- Bytes presented while s_ready = 0 are not consumed. The host must hold them.

## Timing
- Reset values (asynchronous, while reset = 0):
  - State IDLE.
  - s_ready 0, im_we 0, im_addr 0, im_wdata 0.
  - cpu_hold 1, busy 0, load_done 0, err 0.
  - XOR accumulator 0, word counter 0.
- Handshake: a byte transfers on a rising edge where s_valid && s_ready. There is no skid buffer.
- Minimum 3 cycles per instruction word (LO, HI, WRITE). An image of N words takes ≥ 3N + 4 cycles from the start pulse to load_done.
- im_we rises on the cycle after the HI byte is accepted and lasts exactly one cycle.
- load_done and the cpu_hold fall occur on the cycle after the checksum byte is accepted.
- Reset asserted mid-load aborts immediately:
  - No further im_we.
  - cpu_hold stays 1.
  - Words already written are not reverted.

## Structure
- Shared definitions package: the loader state enum and the stream constants (HI reserved-bit mask 8'hFE, default IMEM_DEPTH).
- Single module; no sub-module is warranted. The FSM, 12-bit word counter, address register, 8-bit XOR accumulator and low-byte holding register all live in imem_loader.
- Top-level wiring:
  - cpu_hold ORs into the core's reset path.
  - imem gains the write port (we/addr/wdata).

## Test plan
- Reset check: assert reset low mid-idle → all outputs at reset values; cpu_hold = 1; s_ready = 0.
- Good image: start, then bytes 03 00 A5 01 03 00 00 01 A5 → im_we pulses at addr 0/1/2 with data 0x1A5/0x003/0x100; load_done = 1; cpu_hold = 0; err = 0.
- Empty image: start, then 00 00 00 → DONE with no im_we.
- Bad checksum: the good image with final byte 0xA4 → err = 1, cpu_hold = 1; a following start restarts and a good image then reaches DONE.
- Protocol errors (two cases):
  - HI byte 0x02 → ERR straight from INS_HI, with no write for that word.
  - Count 01 08 (N = 2049) → ERR after CNT_HI.
- Stalls and abort:
  - Random s_valid gaps → identical writes to the good-image case.
  - Reset low during word 2 → IDLE, no further im_we, cpu_hold stays 1.
